// File: rtl/alu_exec_mdu_if.sv
// alu_exec_mdu_if: request/response bundle between the control unit and the
// execute stage.
//   Request  : in_valid/in_ready handshake carrying op, funct3, funct7,
//              alu_op, rs1 and rs2.
//   Response : out_valid/out_ready handshake carrying result, alu_ctrl and
//              illegal, plus the busy status flag.
// master drives requests and accepts responses; slave is the execute unit.
interface alu_exec_mdu_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        op;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [1:0]        alu_op;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   result;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              illegal;
    logic              busy;

    modport master (
        output in_valid, op, funct3, funct7, alu_op, rs1, rs2, out_ready,
        input  in_ready, out_valid, result, alu_ctrl, illegal, busy
    );

    modport slave (
        input  in_valid, op, funct3, funct7, alu_op, rs1, rs2, out_ready,
        output in_ready, out_valid, result, alu_ctrl, illegal, busy
    );
endinterface

// File: rtl/alu_exec_mdu.sv
// alu_exec_mdu: execute stage. Decodes op/funct3/funct7/alu_op, computes the
// result and returns it over a valid/ready handshake.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : alu_exec_mdu_if.slave (request in, registered response out)
// Base RV32I/RV64I ops complete one cycle after acceptance. When the macro
// M_EXT_EN is defined, MUL*/DIV*/REM* run on an iterative shift-add /
// restoring shift-subtract unit for XLEN cycles (busy high meanwhile).
// Without M_EXT_EN those ops complete in one cycle as illegal with result 0.
// An alu_op of 11 is illegal and reports alu_ctrl = ADD code with result 0.
module alu_exec_mdu #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = 5
) (
    input  logic          clk,
    input  logic          reset,
    alu_exec_mdu_if.slave bus
);
    localparam int unsigned SH_W = $clog2(XLEN);

    localparam logic [CTRL_W-1:0] C_ADD  = CTRL_W'(5'b00000);
    localparam logic [CTRL_W-1:0] C_SUB  = CTRL_W'(5'b00001);
    localparam logic [CTRL_W-1:0] C_AND  = CTRL_W'(5'b00010);
    localparam logic [CTRL_W-1:0] C_OR   = CTRL_W'(5'b00011);
    localparam logic [CTRL_W-1:0] C_XOR  = CTRL_W'(5'b00100);
    localparam logic [CTRL_W-1:0] C_SLL  = CTRL_W'(5'b00101);
    localparam logic [CTRL_W-1:0] C_SRL  = CTRL_W'(5'b00110);
    localparam logic [CTRL_W-1:0] C_SLT  = CTRL_W'(5'b00111);
    localparam logic [CTRL_W-1:0] C_SLTU = CTRL_W'(5'b01000);
    localparam logic [CTRL_W-1:0] C_SRA  = CTRL_W'(5'b01001);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              illegal_q, illegal_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;

    logic              accept;
    logic              is_mdu;
    logic              dec_illegal;
    logic [CTRL_W-1:0] dec_ctrl;
    logic [XLEN-1:0]   alu_res;
    logic [SH_W-1:0]   shamt;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.illegal   = illegal_q;
    assign bus.result    = result_q;
    assign bus.alu_ctrl  = alu_ctrl_q;

    // Decode of the presented request into an alu_ctrl code
    always_comb begin
        accept      = bus.in_valid && in_ready_q;
        is_mdu      = (bus.alu_op == 2'b10) && (bus.op == 7'b0110011) &&
                      (bus.funct7 == 7'b0000001);
        dec_ctrl    = C_ADD;
        dec_illegal = 1'b0;
        unique case (bus.alu_op)
            2'b00: dec_ctrl = C_ADD;
            2'b01: dec_ctrl = C_SUB;
            2'b10: begin
                if (is_mdu) begin
                    dec_ctrl = CTRL_W'({2'b10, bus.funct3});
                end else begin
                    unique case (bus.funct3)
                        3'b000: dec_ctrl = ((bus.op == 7'b0110011) && bus.funct7[5]) ? C_SUB : C_ADD;
                        3'b001: dec_ctrl = C_SLL;
                        3'b010: dec_ctrl = C_SLT;
                        3'b011: dec_ctrl = C_SLTU;
                        3'b100: dec_ctrl = C_XOR;
                        3'b101: dec_ctrl = bus.funct7[5] ? C_SRA : C_SRL;
                        3'b110: dec_ctrl = C_OR;
                        3'b111: dec_ctrl = C_AND;
                        default: dec_ctrl = C_ADD;
                    endcase
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Single-cycle base ALU
    always_comb begin
        shamt = bus.rs2[SH_W-1:0];
        unique case (dec_ctrl)
            C_ADD:   alu_res = bus.rs1 + bus.rs2;
            C_SUB:   alu_res = bus.rs1 - bus.rs2;
            C_AND:   alu_res = bus.rs1 & bus.rs2;
            C_OR:    alu_res = bus.rs1 | bus.rs2;
            C_XOR:   alu_res = bus.rs1 ^ bus.rs2;
            C_SLL:   alu_res = bus.rs1 << shamt;
            C_SRL:   alu_res = bus.rs1 >> shamt;
            C_SRA:   alu_res = XLEN'($signed(bus.rs1) >>> shamt);
            C_SLT:   alu_res = XLEN'($signed(bus.rs1) < $signed(bus.rs2));
            C_SLTU:  alu_res = XLEN'(bus.rs1 < bus.rs2);
            default: alu_res = '0;
        endcase
    end

`ifdef M_EXT_EN
    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned PW    = 2 * XLEN;

    logic [XLEN-1:0]  hi_q, lo_q, dvsr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_res_q, neg_rem_q;
    logic             a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]  a_mag, b_mag;
    logic [XLEN:0]    mul_sum, rem_sh, rem_diff;
    logic [XLEN-1:0]  st_hi, st_lo;
    logic [PW-1:0]    prod, prod_s;
    logic [XLEN-1:0]  quo_s, rem_s, mdu_res;
    logic             mdu_div;
    logic             mdu_last;

    // Operand signedness and magnitudes. MUL is treated as unsigned since
    // its low half does not depend on signedness.
    always_comb begin
        a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                   (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                   (bus.funct3 == 3'b110);
        a_neg    = a_signed && bus.rs1[XLEN-1];
        b_neg    = b_signed && bus.rs2[XLEN-1];
        a_mag    = a_neg ? (XLEN'(0) - bus.rs1) : bus.rs1;
        b_mag    = b_neg ? (XLEN'(0) - bus.rs2) : bus.rs2;
    end

    // One iteration plus final sign correction. hi/lo hold the product
    // (multiply) or remainder/quotient (divide).
    always_comb begin
        mdu_div  = alu_ctrl_q[2];
        mdu_last = (cnt_q == CNT_W'(XLEN - 1));
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvsr_q} : {(XLEN+1){1'b0}});
        rem_sh   = {hi_q, lo_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, dvsr_q};
        if (mdu_div) begin
            // rem_diff MSB set means the trial subtraction underflowed
            st_hi = rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0];
            st_lo = {lo_q[XLEN-2:0], ~rem_diff[XLEN]};
        end else begin
            st_hi = mul_sum[XLEN:1];
            st_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod   = {st_hi, st_lo};
        prod_s = neg_res_q ? (PW'(0) - prod) : prod;
        quo_s  = neg_res_q ? (XLEN'(0) - st_lo) : st_lo;
        rem_s  = neg_rem_q ? (XLEN'(0) - st_hi) : st_hi;
        unique case (alu_ctrl_q[2:0])
            3'b000:                 mdu_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: mdu_res = prod_s[PW-1:XLEN];
            3'b100, 3'b101:         mdu_res = quo_s;
            default:                mdu_res = rem_s;
        endcase
    end

    // Iteration registers. A zero divisor keeps the quotient positive so it
    // ends all ones; the remainder then restores to rs1.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            dvsr_q    <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if ((state_q == S_IDLE) && accept && is_mdu) begin
            hi_q      <= '0;
            lo_q      <= bus.funct3[2] ? a_mag : b_mag;
            dvsr_q    <= bus.funct3[2] ? b_mag : a_mag;
            cnt_q     <= '0;
            neg_res_q <= (a_neg ^ b_neg) && !(bus.funct3[2] && (bus.rs2 == '0));
            neg_rem_q <= a_neg;
        end else if (state_q == S_CALC) begin
            hi_q      <= st_hi;
            lo_q      <= st_lo;
            cnt_q     <= cnt_q + CNT_W'(1);
        end
    end
`endif

    // Next state and registered outputs
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        illegal_d   = illegal_q;
        result_d    = result_q;
        alu_ctrl_d  = alu_ctrl_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    in_ready_d = 1'b0;
                    alu_ctrl_d = dec_ctrl;
`ifdef M_EXT_EN
                    if (is_mdu) begin
                        state_d   = S_CALC;
                        busy_d    = 1'b1;
                        illegal_d = 1'b0;
                        result_d  = '0;
                    end else begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        illegal_d   = dec_illegal;
                        result_d    = dec_illegal ? '0 : alu_res;
                    end
`else
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    illegal_d   = dec_illegal || is_mdu;
                    result_d    = (dec_illegal || is_mdu) ? '0 : alu_res;
`endif
                end
            end
`ifdef M_EXT_EN
            S_CALC: begin
                if (mdu_last) begin
                    state_d     = S_DONE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                    result_d    = mdu_res;
                end
            end
`endif
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            illegal_q   <= 1'b0;
            result_q    <= '0;
            alu_ctrl_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            illegal_q   <= illegal_d;
            result_q    <= result_d;
            alu_ctrl_q  <= alu_ctrl_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_mdu.sv
// tb_alu_exec_mdu: randomized and directed checks of alu_exec_mdu (XLEN=32)
// against a 64-bit arithmetic reference model. Follows M_EXT_EN like the RTL.
module tb_alu_exec_mdu;
    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    alu_exec_mdu_if #(.XLEN(XLEN), .CTRL_W(5)) bus ();

    alu_exec_mdu #(.XLEN(XLEN), .CTRL_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V semantics via wide integer arithmetic
    function automatic void model(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [1:0] aop,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [4:0] c,
                                  output logic ill, output logic mdu);
        longint      sa, sb, ub, p;
        logic [63:0] pu;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'h0, b});
        pu  = {32'h0, a} * {32'h0, b};
        mdu = (aop == 2'b10) && (op == 7'h33) && (f7 == 7'h01);
        r   = 32'h0;
        c   = 5'd0;
        ill = 1'b0;
        if (aop == 2'b11) begin
            ill = 1'b1;
        end else if (mdu) begin
            c = {2'b10, f3};
`ifdef M_EXT_EN
            case (f3)
                3'd0: begin p = sa * sb; r = p[31:0]; end
                3'd1: begin p = sa * sb; r = p[63:32]; end
                3'd2: begin p = sa * ub; r = p[63:32]; end
                3'd3: r = pu[63:32];
                3'd4: begin
                    if (b == 32'h0) r = 32'hFFFF_FFFF;
                    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                    else begin p = sa / sb; r = p[31:0]; end
                end
                3'd5: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
                3'd6: begin
                    if (b == 32'h0) r = a;
                    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                    else begin p = sa % sb; r = p[31:0]; end
                end
                default: r = (b == 32'h0) ? a : a % b;
            endcase
`else
            ill = 1'b1;
`endif
        end else if (aop == 2'b00) begin
            c = 5'd0; r = a + b;
        end else if (aop == 2'b01) begin
            c = 5'd1; r = a - b;
        end else begin
            case (f3)
                3'd0: if (op == 7'h33 && f7[5]) begin c = 5'd1; r = a - b; end
                      else begin c = 5'd0; r = a + b; end
                3'd1: begin c = 5'd5; r = a << b[4:0]; end
                3'd2: begin c = 5'd7; r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                3'd3: begin c = 5'd8; r = (a < b) ? 32'd1 : 32'd0; end
                3'd4: begin c = 5'd4; r = a ^ b; end
                3'd5: if (f7[5]) begin c = 5'd9; r = $unsigned($signed(a) >>> b[4:0]); end
                      else begin c = 5'd6; r = a >> b[4:0]; end
                3'd6: begin c = 5'd3; r = a | b; end
                default: begin c = 5'd2; r = a & b; end
            endcase
        end
    endfunction

    // One full transaction with out_ready=1; lit >= 0 also checks a literal result
    task automatic run_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [1:0] aop,
                          input logic [31:0] a, input logic [31:0] b, input longint lit);
        logic [31:0] er;
        logic [4:0]  ec;
        logic        eill, emdu;
        int          lat, busy_cnt, exp_lat, exp_busy;
        model(op, f3, f7, aop, a, b, er, ec, eill, emdu);
        exp_lat  = (emdu && !eill) ? XLEN + 1 : 1;
        exp_busy = (emdu && !eill) ? XLEN : 0;
        @(negedge clk);
        check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(1));
        bus.op = op; bus.funct3 = f3; bus.funct7 = f7; bus.alu_op = aop;
        bus.rs1 = a; bus.rs2 = b; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.rs1 = $urandom;
        bus.rs2 = $urandom;
        lat = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_cnt++;
        end while (!bus.out_valid && lat < XLEN + 8);
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        check({tag, ".result"}, 64'(bus.result), 64'(er));
        check({tag, ".alu_ctrl"}, 64'(bus.alu_ctrl), 64'(ec));
        check({tag, ".illegal"}, 64'(bus.illegal), 64'(eill));
        if (lit >= 0) check({tag, ".literal"}, 64'(bus.result), 64'(lit));
        @(negedge clk);
        check({tag, ".release_valid"}, 64'(bus.out_valid), 64'(0));
        check({tag, ".release_ready"}, 64'(bus.in_ready), 64'(1));
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat, pulses;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [1:0]  aop;
        int          sel;

        reset = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.op = 7'h0; bus.funct3 = 3'h0; bus.funct7 = 7'h0; bus.alu_op = 2'b00;
        bus.rs1 = 32'h0; bus.rs2 = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset.out_valid", 64'(bus.out_valid), 64'(0));
        check("reset.result", 64'(bus.result), 64'(0));
        check("reset.alu_ctrl", 64'(bus.alu_ctrl), 64'(0));
        check("reset.illegal", 64'(bus.illegal), 64'(0));
        check("reset.busy", 64'(bus.busy), 64'(0));
        check("reset.in_ready", 64'(bus.in_ready), 64'(1));

        // Directed corners
        run_op("add",    7'h33, 3'd0, 7'h00, 2'b00, 32'd5, 32'd7, 64'd12);
        run_op("sra",    7'h33, 3'd5, 7'h20, 2'b10, 32'h8000_0000, 32'd4, 64'hF800_0000);
        run_op("srl",    7'h33, 3'd5, 7'h00, 2'b10, 32'h8000_0000, 32'd4, 64'h0800_0000);
        run_op("addi",   7'h13, 3'd0, 7'h20, 2'b10, 32'd9, 32'd3, 64'd12);
        run_op("sub",    7'h33, 3'd0, 7'h00, 2'b01, 32'd3, 32'd5, 64'hFFFF_FFFE);
        run_op("badop",  7'h33, 3'd0, 7'h00, 2'b11, 32'd3, 32'd5, 64'd0);
        run_op("mul",    7'h33, 3'd0, 7'h01, 2'b10, 32'hFFFF_FFFD, 32'd7, -1);
        run_op("mulhu",  7'h33, 3'd3, 7'h01, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op("mulh",   7'h33, 3'd1, 7'h01, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op("mulhsu", 7'h33, 3'd2, 7'h01, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op("div0",   7'h33, 3'd4, 7'h01, 2'b10, 32'd7, 32'd0, -1);
        run_op("remu0",  7'h33, 3'd7, 7'h01, 2'b10, 32'd7, 32'd0, -1);
        run_op("rem0n",  7'h33, 3'd6, 7'h01, 2'b10, 32'hFFFF_FFF9, 32'd0, -1);
        run_op("divovf", 7'h33, 3'd4, 7'h01, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op("removf", 7'h33, 3'd6, 7'h01, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op("divneg", 7'h33, 3'd4, 7'h01, 2'b10, 32'hFFFF_FF9C, 32'd7, -1);
        run_op("remneg", 7'h33, 3'd6, 7'h01, 2'b10, 32'hFFFF_FF9C, 32'd7, -1);

        // Backpressure: result held, new request ignored
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.op = 7'h33; bus.funct3 = 3'd0; bus.funct7 = 7'h00; bus.alu_op = 2'b00;
        bus.rs1 = 32'd9; bus.rs2 = 32'd4; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.out_valid && lat < 8);
        check("bp.latency", 64'(lat), 64'(1));
        for (int i = 0; i < 5; i++) begin
            bus.alu_op = 2'b01; bus.rs1 = 32'd100; bus.rs2 = 32'd1; bus.in_valid = 1'b1;
            @(negedge clk);
            check("bp.result", 64'(bus.result), 64'(13));
            check("bp.in_ready", 64'(bus.in_ready), 64'(0));
            check("bp.out_valid", 64'(bus.out_valid), 64'(1));
            check("bp.alu_ctrl", 64'(bus.alu_ctrl), 64'(0));
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp.release_valid", 64'(bus.out_valid), 64'(0));
        check("bp.release_ready", 64'(bus.in_ready), 64'(1));
        @(negedge clk);
        check("bp.no_ghost", 64'(bus.out_valid), 64'(0));

        // Reset in cycle 10 of a divide
        @(negedge clk);
        bus.op = 7'h33; bus.funct3 = 3'd4; bus.funct7 = 7'h01; bus.alu_op = 2'b10;
        bus.rs1 = 32'd1000; bus.rs2 = 32'd7; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
`ifdef M_EXT_EN
        check("rst.busy_before", 64'(bus.busy), 64'(1));
`endif
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst.busy", 64'(bus.busy), 64'(0));
        check("rst.out_valid", 64'(bus.out_valid), 64'(0));
        check("rst.in_ready", 64'(bus.in_ready), 64'(1));
        pulses = 0;
        repeat (XLEN + 4) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
        end
        check("rst.no_pulse", 64'(pulses), 64'(0));
        run_op("rst.add", 7'h33, 3'd0, 7'h00, 2'b00, 32'd1, 32'd1, 64'd2);

        // Randomized mix
        for (int n = 0; n < 150; n++) begin
            op  = ($urandom_range(0, 1) != 0) ? 7'h33 : 7'h13;
            f3  = 3'($urandom_range(0, 7));
            sel = int'($urandom_range(0, 9));
            aop = (sel < 2) ? 2'b00 : (sel == 2) ? 2'b01 : (sel == 3) ? 2'b11 : 2'b10;
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom_range(0, 127));
            endcase
            run_op("rand", op, f3, f7, aop, pick_val(), pick_val(), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
